// File: rtl/tl_cntr_param.sv
// -----------------------------------------------------------------------------
// tl_cntr_param -- parametrised two-road traffic light controller.
//
// Moore FSM with a per-state cycle timer. Road A green is held for at least
// MIN_GREEN cycles. It ends once road A is empty, or after MAX_GREEN cycles
// when road B has traffic waiting. Yellow lasts YELLOW_CYC cycles. Road B
// mirrors road A.
//
// Optional feature, macro ALL_RED_EN:
//   defined   -> an all-red clearance state (AR after AY, BR after BY) of
//                ALL_RED_CYC cycles sits between yellow and the cross green.
//   undefined -> yellow goes straight to the cross road's green.
//
// Ports:
//   clk      in   rising-edge system clock
//   reset_n  in   synchronous reset, ACTIVE HIGH despite the name
//   Ta, Tb   in   traffic present on road A / road B
//   La, Lb   out  lamp codes: 00 green, 01 yellow, 10 red
//   phase    out  current state code (AG=0 AY=1 BG=2 BY=3 AR=4 BR=5)
//   timer    out  cycles spent in the current state, saturating
// -----------------------------------------------------------------------------
module tl_cntr_param #(
  parameter int CNT_W       = 8,
  parameter int MIN_GREEN   = 3,
  parameter int MAX_GREEN   = 20,
  parameter int YELLOW_CYC  = 5,
  parameter int ALL_RED_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Ta,
  input  logic             Tb,
  output logic [1:0]       La,
  output logic [1:0]       Lb,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer
);

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Thresholds are "duration - 1" because the timer reads 0 in the first
  // cycle of a state.
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_CYC - 1);
`ifdef ALL_RED_EN
  localparam logic [CNT_W-1:0] RED_M1 = CNT_W'(ALL_RED_CYC - 1);
`endif

  // Reject parameter sets the timer cannot represent or that make no sense.
  localparam longint TIMER_MAX = (longint'(1) << CNT_W) - 1;
  generate
    if (CNT_W < 1 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
        YELLOW_CYC < 1 || ALL_RED_CYC < 1 ||
        longint'(MAX_GREEN) > TIMER_MAX || longint'(YELLOW_CYC) > TIMER_MAX ||
        longint'(ALL_RED_CYC) > TIMER_MAX) begin : g_bad_params
      $error("tl_cntr_param: illegal parameter combination");
    end
  endgenerate

  // Encodings double as the phase codes. AR/BR are only reachable with the
  // all-red feature enabled. Codes 6 and 7 fall into the default branches.
  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    BG = 3'd2,
    BY = 3'd3,
    AR = 3'd4,
    BR = 3'd5
  } state_e;

  state_e state;
  state_e next_state;

  // Next-state logic.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    next_state = state;
    case (state)
      AG: if ((timer >= MIN_M1 && !Ta) || (timer >= MAX_M1 && Tb))
            next_state = AY;
      AY: if (timer == YEL_M1)
`ifdef ALL_RED_EN
            next_state = AR;
`else
            next_state = BG;
`endif
      BG: if ((timer >= MIN_M1 && !Tb) || (timer >= MAX_M1 && Ta))
            next_state = BY;
      BY: if (timer == YEL_M1)
`ifdef ALL_RED_EN
            next_state = BR;
`else
            next_state = AG;
`endif
`ifdef ALL_RED_EN
      AR: if (timer == RED_M1) next_state = BG;
      BR: if (timer == RED_M1) next_state = AG;
`endif
      default: next_state = AG;  // illegal code: recover to AG
    endcase
  end

  // State and timer registers. The reset is synchronous and active high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before this edge, whatever the statement order.
    if (reset_n) begin
      state <= AG;
      timer <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        timer <= '0;
      else if (timer != '1)          // saturate, never wrap
        timer <= timer + CNT_W'(1);
    end
  end

  // Moore outputs, decoded from the state register only. Both lamps default
  // to red, so AR, BR and illegal codes show red on both roads.
  always_comb begin
    La = RED;
    Lb = RED;
    case (state)
      AG:      La = GREEN;
      AY:      La = YELLOW;
      BG:      Lb = GREEN;
      BY:      Lb = YELLOW;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_cntr_param.sv
// -----------------------------------------------------------------------------
// tb_tl_cntr_param -- directed self-checking bench for tl_cntr_param.
// Uses the default parameters and a 10 ns clock. Expected phases and timers
// come from a small table of phase durations. The table follows the macro
// ALL_RED_EN, so the bench matches whichever build of the design it is
// compiled with.
// -----------------------------------------------------------------------------
module tb_tl_cntr_param;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             Ta;
  logic             Tb;
  logic [1:0]       La;
  logic [1:0]       Lb;
  logic [2:0]       phase;
  logic [CNT_W-1:0] timer;

  int n_cmp = 0;
  int n_err = 0;

  tl_cntr_param #(
    .CNT_W      (CNT_W),
    .MIN_GREEN  (3),
    .MAX_GREEN  (20),
    .YELLOW_CYC (5),
    .ALL_RED_CYC(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .Ta     (Ta),
    .Tb     (Tb),
    .La     (La),
    .Lb     (Lb),
    .phase  (phase),
    .timer  (timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it. Inputs driven here are seen
  // at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ta, input logic tb);
    reset_n = 1'b1;
    Ta      = ta;
    Tb      = tb;
    tick();
    reset_n = 1'b0;
  endtask

  // Expected phase and timer at cycle c after reset when the sensors stay
  // constant, so the green length g is the same for both roads.
  function automatic void model(input int c, input int g, output int ph, output int tm);
    int ph_seq[6];
    int len_seq[6];
    int n;
    int total;
    int t;
`ifdef ALL_RED_EN
    ph_seq  = '{0, 1, 4, 2, 3, 5};
    len_seq = '{g, 5, 2, g, 5, 2};
    n = 6;
`else
    ph_seq  = '{0, 1, 2, 3, 0, 0};
    len_seq = '{g, 5, g, 5, 0, 0};
    n = 4;
`endif
    total = 0;
    for (int i = 0; i < n; i++) total += len_seq[i];
    t  = c % total;
    ph = 0;
    tm = 0;
    for (int i = 0; i < n; i++) begin
      if (t < len_seq[i]) begin
        ph = ph_seq[i];
        tm = t;
        break;
      end
      t -= len_seq[i];
    end
  endfunction

  function automatic logic [1:0] la_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lb_of(input int ph);
    case (ph)
      2:       return 2'b00;
      3:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    int ph;
    int tm;
    int last;
    int by_at;

    // 1: reset held for two edges, then Ta=1/Tb=0 keeps road A green.
    reset_n = 1'b1;
    Ta = 1'b1;
    Tb = 1'b0;
    tick();
    tick();
    check("rst_la", La, 2'b00);
    check("rst_lb", Lb, 2'b10);
    check("rst_phase", phase, 0);
    check("rst_timer", timer, 0);
    reset_n = 1'b0;
    for (int c = 0; c < 30; c++) begin
      check("s1_la", La, 2'b00);
      check("s1_lb", Lb, 2'b10);
      check("s1_phase", phase, 0);
      check("s1_timer", timer, c);
      if (c < 29) tick();
    end

    // 2 / 5: Ta=0, Tb=1 -> minimum green, yellow, (all-red), then B green.
`ifdef ALL_RED_EN
    last = 10;
`else
    last = 8;
`endif
    do_reset(1'b0, 1'b1);
    for (int c = 0; c <= last; c++) begin
      model(c, 3, ph, tm);
      check("s2_phase", phase, ph);
      check("s2_la", La, la_of(ph));
      check("s2_lb", Lb, lb_of(ph));
      check("s2_timer", timer, tm);
      tick();
    end

    // Both roads empty: alternate after the minimum green each.
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      model(c, 3, ph, tm);
      check("idle_phase", phase, ph);
      check("idle_timer", timer, tm);
      tick();
    end

    // 3: both roads busy -> each green lasts exactly MAX_GREEN cycles.
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 110; c++) begin
      model(c, 20, ph, tm);
      check("s3_phase", phase, ph);
      check("s3_timer", timer, tm);
      check("s3_lamps", {La, Lb}, {la_of(ph), lb_of(ph)});
      check("s3_one_red", (La == 2'b10 || Lb == 2'b10), 1);
      tick();
    end

    // 4: reset asserted in BY at timer=2 returns to AG at the next edge.
`ifdef ALL_RED_EN
    by_at = 47 + 2;
`else
    by_at = 45 + 2;
`endif
    do_reset(1'b1, 1'b1);
    repeat (by_at) tick();
    check("s4_in_by", phase, 3);
    check("s4_by_timer", timer, 2);
    reset_n = 1'b1;
    tick();
    check("s4_la", La, 2'b00);
    check("s4_lb", Lb, 2'b10);
    check("s4_timer", timer, 0);
    check("s4_phase", phase, 0);
    reset_n = 1'b0;

    // 6: timer saturates at 255; cross traffic then ends AG immediately.
    do_reset(1'b1, 1'b0);
    repeat (300) tick();
    check("s6_sat", timer, 255);
    check("s6_phase_ag", phase, 0);
    tick();
    check("s6_sat_hold", timer, 255);
    Tb = 1'b1;
    tick();
    check("s6_to_ay", phase, 1);
    check("s6_ay_timer", timer, 0);
    check("s6_ay_la", La, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tl_cntr_param.md
Name: tl_cntr_param

Overview:
Parametrised two-road traffic light controller, the successor to the fixed two-state-per-road controller. Cycle-count timing replaces the single-cycle phases:
- minimum green time, enforced per road
- maximum green time (starvation timeout) when the cross road has traffic
- multi-cycle yellow
Sits between the road sensor inputs (Ta, Tb) and the lamp drivers (La, Lb). Single clock domain.

Parameters:
- CNT_W, 8: phase timer width in bits.
- MIN_GREEN, 3: minimum green duration, cycles; >=1.
- MAX_GREEN, 20: green timeout when cross traffic waits, cycles; >=MIN_GREEN.
- YELLOW_CYC, 5: yellow duration, cycles; >=1.
- ALL_RED_CYC, 2: all-red clearance duration, cycles; >=1. Used only with ALL_RED_EN.
- All duration values must be <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-high reset: reset_n=1 at a rising edge resets the block. The port name follows the codebase; the polarity and synchronicity are fixed as stated.
- Ta  input  1  traffic present on road A.
- Tb  input  1  traffic present on road B.
- La  output  2  road A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red.
- Lb  output  2  road B lamp, same encoding.
- phase  output  3  current state code, for verification.
- timer  output  CNT_W  cycles spent in the current state.

Behaviour:
- Moore FSM. La, Lb and phase are decoded from the state register only; no combinational path from Ta/Tb to outputs.
- States and phase codes:
  - AG=0: La green, Lb red.
  - AY=1: La yellow, Lb red.
  - BG=2: La red, Lb green.
  - BY=3: La red, Lb yellow.
  - AR=4: both red, after AY (ALL_RED_EN only).
  - BR=5: both red, after BY (ALL_RED_EN only).
  - Codes 6 and 7 are illegal; from either, the next edge goes to AG with timer=0.
- Reset (reset_n=1 at an edge): state=AG, timer=0, La=00, Lb=10, phase=0. This holds from any state, including mid-yellow or mid-all-red.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 each cycle.
  - Saturates at 2^CNT_W-1, no wrap-around.
- AG to AY at the next edge when either:
  - (timer >= MIN_GREEN-1 and Ta=0), or
  - (timer >= MAX_GREEN-1 and Tb=1).
  - Otherwise stay in AG.
  - Ta=1 with Tb=0 holds AG indefinitely; the timer saturates and stays there.
- AY: leave when timer == YELLOW_CYC-1. Next state is BG, or AR with ALL_RED_EN. Sensors are ignored in AY.
- BG to BY: mirror of AG, with Tb in place of Ta and Ta in place of Tb.
- BY: leave when timer == YELLOW_CYC-1. Next state is AG, or BR with ALL_RED_EN.
- Ta=0 and Tb=0 together: roads alternate after MIN_GREEN each (same as the predecessor's alternation when a road empties).
- Ta=1 and Tb=1 together: each road gets exactly MAX_GREEN green cycles, then yellow.
- Sensors are sampled only on rising edges. Pulses shorter than a cycle that do not cover an edge are not seen.
- Invariant: La and Lb are never both non-red.

Optional Feature:
Macro ALL_RED_EN.
- Defined: AR and BR states are present. After each yellow, both lamps show red (10) for ALL_RED_CYC cycles, then the cross road goes green. AR is followed by BG; BR is followed by AG.
- Undefined: AR and BR do not exist. Yellow goes directly to the cross road's green. ALL_RED_CYC is ignored, and phase never takes the values 4 or 5.

Test Plan (all parameters at defaults, 10 ns clock):
1. Hold reset_n=1 for 2 edges, then release with Ta=1, Tb=0 for 30 cycles -> La=00, Lb=10, phase=0 throughout; timer reaches 29.
2. After reset, Ta=0 and Tb=1 from the first cycle, macro undefined ->
   - La=00 for exactly 3 cycles
   - then La=01 for 5 cycles
   - then La=10 and Lb=00, phase=2.
3. Ta=1 and Tb=1 continuously, macro undefined -> repeating sequence: AG 20 cycles, AY 5, BG 20, BY 5. Period 50 cycles. La and Lb are never both non-red.
4. Assert reset_n=1 during BY at timer=2 -> at the next edge La=00, Lb=10, timer=0, phase=0.
5. With ALL_RED_EN defined, repeat scenario 2 -> after the 5 AY cycles, La=Lb=10 for 2 cycles (phase=4), then Lb=00.
6. Ta=1, Tb=0 for 300 cycles with CNT_W=8 -> timer saturates at 255 and holds there. Then set Tb=1 -> AY is entered at the next edge, since timer >= 19.
